// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared write-port types, extension codes and widths
package wb_port_arbiter_pkg;

  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic [3:0] {
    EXT_PASS = 4'd0,
    EXT_SW   = 4'd1,
    EXT_UW   = 4'd2,
    EXT_SH   = 4'd3
  } ext_e;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_MEM,
    SRC_MDU,
    SRC_EX
  } src_e;

  function automatic logic ext_legal(input logic [3:0] ext);
    return ext <= EXT_SH;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - busy bits for outstanding long-latency writes and operand lookup
module wb_scoreboard
  import wb_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic              hit
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // Set is applied after clear so a same-cycle collision leaves the register busy.
  always_comb begin
    busy_next = busy;
    if (clr) busy_next[clr_addr] = 1'b0;
    if (set) busy_next[set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  assign hit = busy[rs1_addr] | busy[rs2_addr];

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - starvation-aware arbiter, extension and output register for the RF write port
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [REG_AW-1:0] ex_waddr,
  input  logic [XLEN-1:0]   ex_wdata,
  input  logic [3:0]        ex_ext,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic [3:0]        mem_ext,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_AW-1:0] mdu_waddr,
  input  logic [XLEN-1:0]   mdu_wdata,
  input  logic [3:0]        mdu_ext,
  input  logic              sb_set,
  input  logic [REG_AW-1:0] sb_set_addr,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic              stall,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              ext_err
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0]     wait_ex, wait_mem, wait_mdu;
  logic              starved_ex, starved_mem, starved_mdu;
  src_e              sel;
  logic              grant, legal, commit_wen, sb_clr, sb_hit, wb_hit;
  logic [REG_AW-1:0] g_waddr;
  logic [XLEN-1:0]   g_wdata;
  logic [3:0]        g_ext;

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [3:0] ext);
    case (ext)
      EXT_SW:  extend = {{(XLEN-32){d[31]}}, d[31:0]};
      EXT_UW:  extend = {{(XLEN-32){1'b0}}, d[31:0]};
      EXT_SH:  extend = {{(XLEN-16){d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  function automatic logic [CW-1:0] next_wait(input logic [CW-1:0] w, input logic valid,
                                              input logic ready);
    if (ready)                    return '0;
    if (valid && (w != LIMIT))    return w + 1'b1;
    return w;
  endfunction

  assign starved_ex  = ex_valid  && (wait_ex  == LIMIT);
  assign starved_mem = mem_valid && (wait_mem == LIMIT);
  assign starved_mdu = mdu_valid && (wait_mdu == LIMIT);

  // Starved requesters preempt; base order mem > mdu > ex breaks ties in both tiers.
  always_comb begin
    sel = SRC_NONE;
    if (starved_mem)      sel = SRC_MEM;
    else if (starved_mdu) sel = SRC_MDU;
    else if (starved_ex)  sel = SRC_EX;
    else if (mem_valid)   sel = SRC_MEM;
    else if (mdu_valid)   sel = SRC_MDU;
    else if (ex_valid)    sel = SRC_EX;
  end

  assign mem_ready = rst_n && (sel == SRC_MEM);
  assign mdu_ready = rst_n && (sel == SRC_MDU);
  assign ex_ready  = rst_n && (sel == SRC_EX);

  always_comb begin
    g_waddr = '0;
    g_wdata = '0;
    g_ext   = '0;
    case (sel)
      SRC_MEM: begin g_waddr = mem_waddr; g_wdata = mem_wdata; g_ext = mem_ext; end
      SRC_MDU: begin g_waddr = mdu_waddr; g_wdata = mdu_wdata; g_ext = mdu_ext; end
      SRC_EX:  begin g_waddr = ex_waddr;  g_wdata = ex_wdata;  g_ext = ex_ext;  end
      default: ;
    endcase
  end

  assign grant      = rst_n && (sel != SRC_NONE);
  assign legal      = ext_legal(g_ext);
  assign commit_wen = grant && legal && (g_waddr != '0);
  // Any accepted long-latency result releases its register, even a dropped illegal one.
  assign sb_clr     = grant && ((sel == SRC_MEM) || (sel == SRC_MDU));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      ext_err  <= 1'b0;
      wait_ex  <= '0;
      wait_mem <= '0;
      wait_mdu <= '0;
    end else begin
      rf_wen  <= commit_wen;
      ext_err <= grant && !legal;
      if (commit_wen) begin
        rf_waddr <= g_waddr;
        rf_wdata <= extend(g_wdata, g_ext);
      end
      wait_ex  <= next_wait(wait_ex,  ex_valid,  ex_ready);
      wait_mem <= next_wait(wait_mem, mem_valid, mem_ready);
      wait_mdu <= next_wait(wait_mdu, mdu_valid, mdu_ready);
    end
  end

  wb_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set      (sb_set),
    .set_addr (sb_set_addr),
    .clr      (sb_clr),
    .clr_addr (g_waddr),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .hit      (sb_hit)
  );

  // The write in flight is invisible to the busy bits, so compare against it directly.
  assign wb_hit = rf_wen && (rf_waddr != '0) &&
                  ((rf_waddr == rs1_addr) || (rf_waddr == rs2_addr));
  assign stall  = sb_hit || wb_hit;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;

  logic        clk, rst_n;
  logic        ex_valid, mem_valid, mdu_valid;
  logic        ex_ready, mem_ready, mdu_ready;
  logic [4:0]  ex_waddr, mem_waddr, mdu_waddr;
  logic [63:0] ex_wdata, mem_wdata, mdu_wdata;
  logic [3:0]  ex_ext, mem_ext, mdu_ext;
  logic        sb_set;
  logic [4:0]  sb_set_addr, rs1_addr, rs2_addr;
  logic        stall, rf_wen, ext_err;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  wb_port_arbiter #(.STARVE_LIMIT(4), .XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_ext(ex_ext),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_ext(mem_ext),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .mdu_ext(mdu_ext),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .stall(stall), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ext_err(ext_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic wen, input logic [4:0] a, input logic [63:0] d, input logic err);
    exp_t e;
    e.wen = wen; e.addr = a; e.data = d; e.err = err;
    expq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] a, input logic [63:0] d, input logic [3:0] e);
    ex_valid = v; ex_waddr = a; ex_wdata = d; ex_ext = e;
  endtask
  task automatic set_mem(input logic v, input logic [4:0] a, input logic [63:0] d, input logic [3:0] e);
    mem_valid = v; mem_waddr = a; mem_wdata = d; mem_ext = e;
  endtask
  task automatic set_mdu(input logic v, input logic [4:0] a, input logic [63:0] d, input logic [3:0] e);
    mdu_valid = v; mdu_waddr = a; mdu_wdata = d; mdu_ext = e;
  endtask

  // who: 0 none, 1 mem, 2 mdu, 3 ex; all contention traffic uses pass-through ext.
  task automatic grant_cycle(input int who, input string tag);
    @(negedge clk);
    chk({tag, "_mem_ready"}, mem_ready, who == 1);
    chk({tag, "_mdu_ready"}, mdu_ready, who == 2);
    chk({tag, "_ex_ready"},  ex_ready,  who == 3);
    if (who == 1) push(1'b1, mem_waddr, mem_wdata, 1'b0);
    if (who == 2) push(1'b1, mdu_waddr, mdu_wdata, 1'b0);
    if (who == 3) push(1'b1, ex_waddr,  ex_wdata,  1'b0);
    tick();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (rf_wen || ext_err)) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: rf_wen=%0b ext_err=%0b addr=%0d, nothing expected",
                 rf_wen, ext_err, rf_waddr);
      end else begin
        e = expq.pop_front();
        chk("commit_wen", rf_wen, e.wen);
        chk("commit_err", ext_err, e.err);
        if (e.wen) begin
          chk("commit_addr", rf_waddr, e.addr);
          chk("commit_data", rf_wdata, e.data);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    set_ex(1'b1, 5'd0, 64'd0, 4'd0);
    set_mem(1'b0, 5'd0, 64'd0, 4'd0);
    set_mdu(1'b0, 5'd0, 64'd0, 4'd0);
    sb_set = 1'b0; sb_set_addr = 5'd0; rs1_addr = 5'd7; rs2_addr = 5'd9;

    @(negedge clk);
    chk("reset_rf_wen",   rf_wen,   1'b0);
    chk("reset_ext_err",  ext_err,  1'b0);
    chk("reset_rf_waddr", rf_waddr, 5'd0);
    chk("reset_rf_wdata", rf_wdata, 64'd0);
    chk("reset_stall",    stall,    1'b0);
    chk("reset_ex_ready", ex_ready, 1'b0);
    tick();
    rst_n = 1'b1;

    set_ex(1'b1, 5'd5, 64'hFFFF_FFFF_8000_0000, 4'd1);
    @(negedge clk);
    chk("sext32_ready", ex_ready, 1'b1);
    push(1'b1, 5'd5, 64'hFFFF_FFFF_8000_0000, 1'b0);
    tick();
    set_ex(1'b1, 5'd5, 64'hFFFF_FFFF_8000_0000, 4'd2);
    @(negedge clk);
    chk("zext32_ready", ex_ready, 1'b1);
    push(1'b1, 5'd5, 64'h0000_0000_8000_0000, 1'b0);
    tick();
    set_ex(1'b1, 5'd6, 64'h0000_0000_0000_8000, 4'd3);
    @(negedge clk);
    push(1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_8000, 1'b0);
    tick();
    set_ex(1'b1, 5'd6, 64'h1234_5678_9ABC_DEF0, 4'd0);
    @(negedge clk);
    push(1'b1, 5'd6, 64'h1234_5678_9ABC_DEF0, 1'b0);
    tick();
    ex_valid = 1'b0;
    tick();

    set_mem(1'b1, 5'd10, 64'hA, 4'd0);
    set_ex(1'b1, 5'd11, 64'hB, 4'd0);
    for (int i = 0; i < 4; i++) grant_cycle(1, "me_mem_wins");
    grant_cycle(3, "me_ex_starved");
    grant_cycle(1, "me_ex_cleared");
    mem_valid = 1'b0;
    grant_cycle(3, "me_ex_alone");
    ex_valid = 1'b0;
    tick();

    set_mem(1'b1, 5'd10, 64'hA, 4'd0);
    set_mdu(1'b1, 5'd12, 64'hC, 4'd0);
    set_ex(1'b1, 5'd11, 64'hB, 4'd0);
    for (int i = 0; i < 4; i++) grant_cycle(1, "all_mem_wins");
    grant_cycle(2, "all_mdu_tie");
    grant_cycle(3, "all_ex_next");
    grant_cycle(1, "all_mem_back");
    mem_valid = 1'b0; ex_valid = 1'b0;
    grant_cycle(2, "all_mdu_alone");
    mdu_valid = 1'b0;
    tick();

    sb_set = 1'b1; sb_set_addr = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd0;
    @(negedge clk);
    chk("sb_before_set", stall, 1'b0);
    tick();
    sb_set = 1'b0;
    @(negedge clk);
    chk("sb_rs1_busy", stall, 1'b1);
    rs1_addr = 5'd0; rs2_addr = 5'd7;
    #1 chk("sb_rs2_busy", stall, 1'b1);
    rs2_addr = 5'd8;
    #1 chk("sb_idle_reg", stall, 1'b0);
    rs1_addr = 5'd7; rs2_addr = 5'd0;
    tick();
    set_mdu(1'b1, 5'd7, 64'h77, 4'd0);
    @(negedge clk);
    chk("mdu_x7_ready", mdu_ready, 1'b1);
    chk("mdu_x7_stall_grant", stall, 1'b1);
    push(1'b1, 5'd7, 64'h77, 1'b0);
    tick();
    mdu_valid = 1'b0;
    @(negedge clk);
    chk("mdu_x7_stall_commit", stall, 1'b1);
    tick();
    @(negedge clk);
    chk("mdu_x7_stall_after", stall, 1'b0);
    tick();

    sb_set = 1'b1; sb_set_addr = 5'd9; rs1_addr = 5'd9;
    set_mem(1'b1, 5'd9, 64'h99, 4'd0);
    @(negedge clk);
    chk("x9_mem_ready", mem_ready, 1'b1);
    push(1'b1, 5'd9, 64'h99, 1'b0);
    tick();
    sb_set = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    chk("x9_stall_commit", stall, 1'b1);
    tick();
    @(negedge clk);
    chk("x9_set_wins", stall, 1'b1);
    tick();

    set_mem(1'b1, 5'd0, 64'h55, 4'd0);
    @(negedge clk);
    chk("x0_mem_ready", mem_ready, 1'b1);
    tick();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("x0_rf_wen", rf_wen, 1'b0);
    chk("x0_ext_err", ext_err, 1'b0);
    tick();

    set_ex(1'b1, 5'd3, 64'h66, 4'd7);
    @(negedge clk);
    chk("illegal_ex_ready", ex_ready, 1'b1);
    push(1'b0, 5'd3, 64'h66, 1'b1);
    tick();
    ex_valid = 1'b0;
    @(negedge clk);
    chk("illegal_ext_err", ext_err, 1'b1);
    chk("illegal_rf_wen", rf_wen, 1'b0);
    tick();
    @(negedge clk);
    chk("illegal_err_pulse", ext_err, 1'b0);
    tick();

    set_ex(1'b1, 5'd4, 64'h44, 4'd0);
    @(negedge clk);
    chk("pre_reset_ready", ex_ready, 1'b1);
    tick();
    chk("pre_reset_rf_wen", rf_wen, 1'b1);
    chk("pre_reset_stall", stall, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rf_wen",   rf_wen,   1'b0);
    chk("async_rf_waddr", rf_waddr, 5'd0);
    chk("async_rf_wdata", rf_wdata, 64'd0);
    chk("async_ext_err",  ext_err,  1'b0);
    chk("async_stall",    stall,    1'b0);
    chk("async_ex_ready", ex_ready, 1'b0);
    tick();
    chk("reset_busy_clear", stall, 1'b0);
    ex_valid = 1'b0;
    rst_n = 1'b1;
    set_mem(1'b1, 5'd13, 64'hDEAD_BEEF_8765_4321, 4'd2);
    rs1_addr = 5'd13;
    @(negedge clk);
    chk("post_reset_ready", mem_ready, 1'b1);
    push(1'b1, 5'd13, 64'h0000_0000_8765_4321, 1'b0);
    tick();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_wb_stall", stall, 1'b1);
    tick();
    tick();
    chk("queue_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
